// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - double-buffered 3-channel 8-bit PWM driver with active-low LED pins
// Optional square-law gamma on the pending->active copy when RGB_PWM_GAMMA_EN is defined.
module rgb_pwm_driver #(
  parameter int DIV = 256
) (
  input  logic       clk_24MHz_i,
  input  logic       rst_i,
  input  logic [7:0] duty_r_i,
  input  logic [7:0] duty_g_i,
  input  logic [7:0] duty_b_i,
  input  logic       duty_valid_i,
  output logic       duty_ready_o,
  output logic       period_start_o,
  output logic       LED_R_n_o,
  output logic       LED_G_n_o,
  output logic       LED_B_n_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [7:0]    slot;
  logic          tick;
  logic          boundary;
  logic          accept;
  logic          full;
  logic [7:0]    pend_r, pend_g, pend_b;
  logic [7:0]    act_r, act_g, act_b;

  function automatic logic [7:0] shape(input logic [7:0] d);
`ifdef RGB_PWM_GAMMA_EN
    logic [15:0] p;
    p = 16'(d) * 16'(d) + 16'd255;
    return 8'(p >> 8);
`else
    return d;
`endif
  endfunction

  assign tick         = (pre == PRE_MAX);
  assign boundary     = tick && (slot == 8'hFF);
  assign duty_ready_o = ~full & ~rst_i;
  assign accept       = duty_valid_i & duty_ready_o;

  always_ff @(posedge clk_24MHz_i or posedge rst_i) begin
    if (rst_i) begin
      pre  <= '0;
      slot <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) slot <= slot + 8'd1;
    end
  end

  // Pending is empty whenever an accept can happen, so boundary copy and accept never collide.
  always_ff @(posedge clk_24MHz_i or posedge rst_i) begin
    if (rst_i) begin
      full   <= 1'b0;
      pend_r <= '0;
      pend_g <= '0;
      pend_b <= '0;
      act_r  <= '0;
      act_g  <= '0;
      act_b  <= '0;
    end else begin
      if (boundary && full) begin
        act_r <= shape(pend_r);
        act_g <= shape(pend_g);
        act_b <= shape(pend_b);
        full  <= 1'b0;
      end else if (accept) begin
        pend_r <= duty_r_i;
        pend_g <= duty_g_i;
        pend_b <= duty_b_i;
        full   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_24MHz_i or posedge rst_i) begin
    if (rst_i) begin
      period_start_o <= 1'b0;
      LED_R_n_o      <= 1'b1;
      LED_G_n_o      <= 1'b1;
      LED_B_n_o      <= 1'b1;
    end else begin
      period_start_o <= (pre == '0) && (slot == 8'd0);
      LED_R_n_o      <= ~(slot < act_r);
      LED_G_n_o      <= ~(slot < act_g);
      LED_B_n_o      <= ~(slot < act_b);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - directed self-checking bench for rgb_pwm_driver (DIV=4)
module tb_rgb_pwm_driver;

  localparam int DIV = 4;
  localparam int PER = 256 * DIV;

  logic       clk_24MHz_i = 1'b0;
  logic       rst_i;
  logic [7:0] duty_r_i, duty_g_i, duty_b_i;
  logic       duty_valid_i;
  logic       duty_ready_o, period_start_o;
  logic       LED_R_n_o, LED_G_n_o, LED_B_n_o;

  int n_cmp = 0;
  int n_bad = 0;

  rgb_pwm_driver #(.DIV(DIV)) dut (
    .clk_24MHz_i   (clk_24MHz_i),
    .rst_i         (rst_i),
    .duty_r_i      (duty_r_i),
    .duty_g_i      (duty_g_i),
    .duty_b_i      (duty_b_i),
    .duty_valid_i  (duty_valid_i),
    .duty_ready_o  (duty_ready_o),
    .period_start_o(period_start_o),
    .LED_R_n_o     (LED_R_n_o),
    .LED_G_n_o     (LED_G_n_o),
    .LED_B_n_o     (LED_B_n_o)
  );

  always #5 clk_24MHz_i = ~clk_24MHz_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int expd(input int d);
`ifdef RGB_PWM_GAMMA_EN
    return (d * d + 255) >> 8;
`else
    return d;
`endif
  endfunction

  task automatic drive(input int r, input int g, input int b);
    duty_r_i     = 8'(r);
    duty_g_i     = 8'(g);
    duty_b_i     = 8'(b);
    duty_valid_i = 1'b1;
  endtask

  // Advance to the next negedge where period_start_o is high.
  task automatic wait_ps();
    int n = 0;
    @(negedge clk_24MHz_i);
    while (!period_start_o && n < 2 * PER) begin
      @(negedge clk_24MHz_i);
      n++;
    end
    if (!period_start_o) chk("ps_timeout", 0, 1);
  endtask

  // Counts low (lit) samples over one period, starting at the current period_start negedge.
  task automatic measure(input string tag, input int dr, input int dg, input int db);
    int cr = 0, cg = 0, cb = 0;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk_24MHz_i);
      cr += int'(!LED_R_n_o);
      cg += int'(!LED_G_n_o);
      cb += int'(!LED_B_n_o);
    end
    chk({tag, "_r"}, cr, expd(dr) * DIV);
    chk({tag, "_g"}, cg, expd(dg) * DIV);
    chk({tag, "_b"}, cb, expd(db) * DIV);
  endtask

  initial begin
    int n;
    rst_i        = 1'b1;
    duty_valid_i = 1'b0;
    duty_r_i     = '0;
    duty_g_i     = '0;
    duty_b_i     = '0;
    repeat (3) @(negedge clk_24MHz_i);
    chk("rst_led_r", int'(LED_R_n_o), 1);
    chk("rst_led_g", int'(LED_G_n_o), 1);
    chk("rst_led_b", int'(LED_B_n_o), 1);
    chk("rst_ready", int'(duty_ready_o), 0);
    chk("rst_ps", int'(period_start_o), 0);

    rst_i = 1'b0;
    #1 chk("rel_ready", int'(duty_ready_o), 1);
    @(negedge clk_24MHz_i);
    chk("rel_ps_first", int'(period_start_o), 1);
    n = 0;
    do begin
      @(negedge clk_24MHz_i);
      n++;
    end while (!period_start_o && n < 2 * PER);
    chk("ps_interval", n, PER);

    drive(64, 0, 255);
    @(negedge clk_24MHz_i);
    duty_valid_i = 1'b0;
    chk("acc_ready_low", int'(duty_ready_o), 0);
    wait_ps();
    chk("acc_ready_back", int'(duty_ready_o), 1);
    measure("basic", 64, 0, 255);

    wait_ps();
    drive(10, 20, 30);
    @(negedge clk_24MHz_i);
    chk("bp_first_taken", int'(duty_ready_o), 0);
    drive(100, 150, 200);
    n = 0;
    while (!duty_ready_o && n < 2 * PER) begin
      @(negedge clk_24MHz_i);
      n++;
    end
    chk("bp_wait", n, PER - 2);
    wait_ps();
    duty_valid_i = 1'b0;
    chk("bp_second_taken", int'(duty_ready_o), 0);
    measure("bp_a", 10, 20, 30);
    wait_ps();
    measure("bp_b", 100, 150, 200);

    wait_ps();
    repeat (PER - 2) @(negedge clk_24MHz_i);
    chk("coin_ready", int'(duty_ready_o), 1);
    drive(50, 60, 70);
    @(negedge clk_24MHz_i);
    duty_valid_i = 1'b0;
    chk("coin_taken", int'(duty_ready_o), 0);
    wait_ps();
    measure("coin_old", 100, 150, 200);
    wait_ps();
    measure("coin_new", 50, 60, 70);

    wait_ps();
    drive(200, 200, 200);
    @(negedge clk_24MHz_i);
    duty_valid_i = 1'b0;
    wait_ps();
    repeat (100) @(negedge clk_24MHz_i);
    chk("mid_lit", int'(LED_R_n_o), 0);
    rst_i = 1'b1;
    #1;
    chk("arst_led_r", int'(LED_R_n_o), 1);
    chk("arst_led_g", int'(LED_G_n_o), 1);
    chk("arst_led_b", int'(LED_B_n_o), 1);
    chk("arst_ready", int'(duty_ready_o), 0);
    repeat (3) @(negedge clk_24MHz_i);
    rst_i = 1'b0;
    wait_ps();
    measure("post_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
